// File: rtl/dlx_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for the DLX core, one instruction at a time.
// Define DLX_SEQ_WATCHDOG_EN to add the mem_ack watchdog and the sticky ERR fault state.

module dlx_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mem_ack,
    input  logic [1:0] type_inst,
    input  logic [5:0] opcode,
    input  logic       enable_write,
    input  logic       read_word,
    input  logic       enable_reg,
    input  logic       link,
    input  logic       load_new_PC,
    input  logic       rs1_zero,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_load,
    output logic       pc_load,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       rd_r31,
    output logic       busy,
    output logic       retire,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [1:0] TYPE_J = 2'b10;
    localparam logic [1:0] TYPE_I = 2'b11;

    state_t state_q, state_d;
    logic   is_mem_q, is_mem_d;
    logic   is_load_q, is_load_d;
    logic   is_store_q, is_store_d;
    logic   br_eqz_q, br_eqz_d;
    logic   br_nez_q, br_nez_d;
    logic   is_jr_q, is_jr_d;
    logic   is_j_q, is_j_d;
    logic   wb_need_q, wb_need_d;
    logic   link_q, link_d;
    logic   is_br;
    logic   boundary;
    logic   wdt_hit;

    // The decoder flag only matters to the datapath; the sequencer always loads the PC in EXEC.
    logic   unused_load_new_pc;
    assign unused_load_new_pc = load_new_PC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_mem_q   <= 1'b0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            br_eqz_q   <= 1'b0;
            br_nez_q   <= 1'b0;
            is_jr_q    <= 1'b0;
            is_j_q     <= 1'b0;
            wb_need_q  <= 1'b0;
            link_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_mem_q   <= is_mem_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            br_eqz_q   <= br_eqz_d;
            br_nez_q   <= br_nez_d;
            is_jr_q    <= is_jr_d;
            is_j_q     <= is_j_d;
            wb_need_q  <= wb_need_d;
            link_q     <= link_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        is_mem_d     = is_mem_q;
        is_load_d    = is_load_q;
        is_store_d   = is_store_q;
        br_eqz_d     = br_eqz_q;
        br_nez_d     = br_nez_q;
        is_jr_d      = is_jr_q;
        is_j_d       = is_j_q;
        wb_need_d    = wb_need_q;
        link_d       = link_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_load      = 1'b0;
        pc_src       = 2'b00;
        reg_we       = 1'b0;
        wb_sel       = 2'b00;
        rd_r31       = 1'b0;
        retire       = 1'b0;
        err          = 1'b0;
        boundary     = 1'b0;
        busy         = (state_q != S_IDLE) && (state_q != S_ERR);
        is_br        = (type_inst == TYPE_I) && ((opcode == 6'h04) || (opcode == 6'h05));

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (wdt_hit) begin
                    state_d = S_ERR;
                end else if (mem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                is_mem_d   = read_word | enable_write;
                is_load_d  = read_word;
                is_store_d = enable_write;
                br_eqz_d   = (type_inst == TYPE_I) && (opcode == 6'h04);
                br_nez_d   = (type_inst == TYPE_I) && (opcode == 6'h05);
                is_jr_d    = (type_inst == TYPE_I) && ((opcode == 6'h12) || (opcode == 6'h13));
                is_j_d     = (type_inst == TYPE_J);
                // JR and plain J carry no result even if the decoder flags a register write.
                wb_need_d  = (enable_reg | link) &&
                             !(is_br || ((type_inst == TYPE_I) && (opcode == 6'h12)) ||
                               ((type_inst == TYPE_J) && (opcode == 6'h02)));
                link_d     = link;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                pc_load = 1'b1;
                if (is_jr_q)
                    pc_src = 2'b10;
                else if (is_j_q || (br_eqz_q && rs1_zero) || (br_nez_q && !rs1_zero))
                    pc_src = 2'b01;
                if (is_mem_q)
                    state_d = S_MEM;
                else if (wb_need_q)
                    state_d = S_WB;
                else
                    boundary = 1'b1;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store_q;
                if (wdt_hit) begin
                    state_d = S_ERR;
                end else if (mem_ack) begin
                    if (is_load_q)
                        state_d = S_WB;
                    else
                        boundary = 1'b1;
                end
            end
            S_WB: begin
                reg_we   = 1'b1;
                wb_sel   = is_load_q ? 2'b01 : (link_q ? 2'b10 : 2'b00);
                rd_r31   = link_q;
                boundary = 1'b1;
            end
            S_ERR: begin
`ifdef DLX_SEQ_WATCHDOG_EN
                err = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (boundary) begin
            retire  = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

`ifdef DLX_SEQ_WATCHDOG_EN
    localparam int WDT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(TIMEOUT_CYCLES);

    logic [WDT_W-1:0] wdt_q, wdt_d;

    assign wdt_hit = (wdt_q == WDT_LIMIT);

    // Counts unanswered request cycles; any ack or leaving FETCH/MEM restarts it.
    always_comb begin
        wdt_d = '0;
        if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack && !wdt_hit)
            wdt_d = wdt_q + WDT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wdt_q <= '0;
        else
            wdt_q <= wdt_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wdt_hit = 1'b0;
`endif

endmodule

// File: tb/tb_dlx_sequencer.sv
// Directed self-checking bench for dlx_sequencer: reset, instruction latencies, PC/WB selects,
// run drop, asynchronous reset mid-instruction and the watchdog (or its absence).

module tb_dlx_sequencer;

    logic       clk;
    logic       reset;
    logic       run;
    logic       mem_ack;
    logic [1:0] type_inst;
    logic [5:0] opcode;
    logic       enable_write;
    logic       read_word;
    logic       enable_reg;
    logic       link;
    logic       load_new_PC;
    logic       rs1_zero;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_load;
    logic       pc_load;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       rd_r31;
    logic       busy;
    logic       retire;
    logic       err;

    int checks = 0;
    int errors = 0;

    dlx_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .mem_ack      (mem_ack),
        .type_inst    (type_inst),
        .opcode       (opcode),
        .enable_write (enable_write),
        .read_word    (read_word),
        .enable_reg   (enable_reg),
        .link         (link),
        .load_new_PC  (load_new_PC),
        .rs1_zero     (rs1_zero),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_load      (ir_load),
        .pc_load      (pc_load),
        .pc_src       (pc_src),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .rd_r31       (rd_r31),
        .busy         (busy),
        .retire       (retire),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

    function automatic logic [31:0] outVec();
        return {18'd0, mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_src,
                reg_we, wb_sel, rd_r31, busy, retire, err};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] ti, input logic [5:0] op, input logic ew,
                                 input logic rw, input logic er, input logic lk, input logic rz);
        type_inst    = ti;
        opcode       = op;
        enable_write = ew;
        read_word    = rw;
        enable_reg   = er;
        link         = lk;
        rs1_zero     = rz;
        load_new_PC  = 1'b0;
    endtask

    // Entered at the start of a FETCH cycle; walks the instruction cycle by cycle until retire.
    task automatic runInstr(input string tag, input logic [1:0] ti, input logic [5:0] op,
                            input logic ew, input logic rw, input logic er, input logic lk,
                            input logic rz, input int fw, input int mw, input bit drop_run,
                            input int exp_cycles, input logic [1:0] exp_pc_src,
                            input logic exp_reg_we, input logic [1:0] exp_wb_sel,
                            input logic exp_rd_r31, input logic exp_mem_we);
        int         cyc        = 0;
        int         f_waits    = 0;
        int         m_waits    = 0;
        int         retire_cyc = 0;
        logic       prev_ir    = 1'b0;
        logic       saw_wb     = 1'b0;
        logic       got_mem_we = 1'b0;
        logic       got_rd_r31 = 1'b0;
        logic [1:0] got_pc_src = 2'b11;
        logic [1:0] got_wb_sel = 2'b11;
        applyStimulus(ti, op, ew, rw, er, lk, rz);
        while (retire_cyc == 0 && cyc < 40) begin
            cyc++;
            mem_ack = 1'b0;
            if (drop_run && prev_ir) run = 1'b0;
            if (mem_req) begin
                if (!mem_addr_sel) begin
                    if (f_waits >= fw) mem_ack = 1'b1;
                    else f_waits++;
                end else begin
                    if (m_waits >= mw) mem_ack = 1'b1;
                    else m_waits++;
                end
            end
            #4;
            if (pc_load) got_pc_src = pc_src;
            if (reg_we) begin
                saw_wb     = 1'b1;
                got_wb_sel = wb_sel;
                got_rd_r31 = rd_r31;
            end
            if (mem_req && mem_addr_sel && mem_we) got_mem_we = 1'b1;
            prev_ir = ir_load;
            if (retire) retire_cyc = cyc;
            stepCycle();
        end
        checkOutput({tag, "_retire_cycle"}, 32'(retire_cyc), 32'(exp_cycles));
        checkOutput({tag, "_pc_src"}, 32'(got_pc_src), 32'(exp_pc_src));
        checkOutput({tag, "_reg_we"}, 32'(saw_wb), 32'(exp_reg_we));
        checkOutput({tag, "_mem_we"}, 32'(got_mem_we), 32'(exp_mem_we));
        if (exp_reg_we) begin
            checkOutput({tag, "_wb_sel"}, 32'(got_wb_sel), 32'(exp_wb_sel));
            checkOutput({tag, "_rd_r31"}, 32'(got_rd_r31), 32'(exp_rd_r31));
        end
    endtask

    initial begin
        reset   = 1'b1;
        run     = 1'b0;
        mem_ack = 1'b0;
        applyStimulus(2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", outVec(), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #4;
            checkOutput("idle_outputs", outVec(), 32'd0);
            stepCycle();
        end

        $display("[TB] instruction sequence");
        run = 1'b1;
        stepCycle();
        runInstr("add",       2'b01, 6'h20, 0, 0, 1, 0, 0, 0, 0, 0, 4, 2'b00, 1, 2'b00, 0, 0);
        runInstr("lw_wait",   2'b11, 6'h23, 0, 1, 1, 0, 0, 2, 2, 0, 9, 2'b00, 1, 2'b01, 0, 0);
        runInstr("sw_wait",   2'b11, 6'h2b, 1, 0, 0, 0, 0, 0, 1, 0, 5, 2'b00, 0, 2'b00, 0, 1);
        runInstr("beqz_tk",   2'b11, 6'h04, 0, 0, 1, 0, 1, 0, 0, 0, 3, 2'b01, 0, 2'b00, 0, 0);
        runInstr("beqz_nt",   2'b11, 6'h04, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2'b00, 0, 2'b00, 0, 0);
        runInstr("bnez_nt",   2'b11, 6'h05, 0, 0, 0, 0, 1, 0, 0, 0, 3, 2'b00, 0, 2'b00, 0, 0);
        runInstr("bnez_tk",   2'b11, 6'h05, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2'b01, 0, 2'b00, 0, 0);
        runInstr("jalr",      2'b11, 6'h13, 0, 0, 0, 1, 0, 0, 0, 0, 4, 2'b10, 1, 2'b10, 1, 0);
        runInstr("jr",        2'b11, 6'h12, 0, 0, 1, 0, 0, 0, 0, 0, 3, 2'b10, 0, 2'b00, 0, 0);
        runInstr("j",         2'b10, 6'h02, 0, 0, 0, 0, 0, 1, 0, 0, 4, 2'b01, 0, 2'b00, 0, 0);
        runInstr("jal",       2'b10, 6'h03, 0, 0, 0, 1, 0, 0, 0, 0, 4, 2'b01, 1, 2'b10, 1, 0);
        runInstr("add_drop",  2'b01, 6'h20, 0, 0, 1, 0, 0, 0, 0, 1, 4, 2'b00, 1, 2'b00, 0, 0);
        #4;
        checkOutput("rundrop_idle", outVec(), 32'd0);
        repeat (3) stepCycle();
        #4;
        checkOutput("rundrop_stay_idle", outVec(), 32'd0);

        $display("[TB] reset mid-instruction");
        run     = 1'b1;
        mem_ack = 1'b1;
        applyStimulus(2'b01, 6'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        stepCycle();
        #2;
        checkOutput("midreset_exec_pc_load", 32'(pc_load), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midreset_async_clear", outVec(), 32'd0);
        stepCycle();
        run     = 1'b0;
        mem_ack = 1'b0;
        reset   = 1'b0;
        #4;
        checkOutput("midreset_after_release", outVec(), 32'd0);

        $display("[TB] memory never acknowledges");
        run     = 1'b1;
        mem_ack = 1'b0;
        stepCycle();
`ifdef DLX_SEQ_WATCHDOG_EN
        for (int i = 0; i < 5; i++) begin
            #4;
            checkOutput("wdt_waiting", 32'({mem_req, err, busy}), 32'b101);
            stepCycle();
        end
        #4;
        checkOutput("wdt_err_state", outVec(), 32'd1);
        mem_ack = 1'b1;
        repeat (3) stepCycle();
        #4;
        checkOutput("wdt_err_sticky", outVec(), 32'd1);
`else
        repeat (12) stepCycle();
        #4;
        checkOutput("nowdt_still_fetch", 32'({mem_req, err, busy}), 32'b101);
`endif
        reset = 1'b1;
        #1;
        checkOutput("final_reset_clear", outVec(), 32'd0);
        stepCycle();
        reset   = 1'b0;
        run     = 1'b0;
        mem_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlx_sequencer.md
# dlx_sequencer

Multicycle control FSM for the DLX core. It sequences one instruction at a time through fetch, decode, execute, memory and write-back, and drives the memory handshake and the PC/register-file enables. It consumes the instruction decoder's combinational outputs and the register file's zero flag. It also owns the memory-access watchdog.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of wait cycles on `mem_ack` before the sequencer faults (watchdog builds only).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `run` in 1: enables execution; sampled at instruction boundaries.
- `mem_ack` in 1: memory completion; may be asserted in the same cycle as `mem_req`.
- `type_inst` in 2: decoder instruction class: 01 = R, 10 = J, 11 = I.
- `opcode` in 6: decoder opcode. For R-type this is the funct field.
- `enable_write`, `read_word`, `enable_reg`, `link`, `load_new_PC` in 1 each: decoder control flags.
- `rs1_zero` in 1: register-file flag, high when Rs1 == 0.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1: store request.
- `mem_addr_sel` out 1: memory address source. 0 = PC, 1 = ALU result.
- `ir_load` out 1: capture the instruction register and NPC (PC+4).
- `pc_load` out 1: update the PC.
- `pc_src` out 2: PC source. 00 = NPC, 01 = NPC + target (imm for branches, value for J/JAL), 10 = Rs1.
- `reg_we` out 1: register-file write.
- `wb_sel` out 2: write-back source. 00 = ALU, 01 = memory data, 10 = NPC.
- `rd_r31` out 1: force the write destination to r31.
- `busy` out 1: high in every state except IDLE and ERR.
- `retire` out 1: one-cycle pulse per completed instruction.
- `err` out 1: sticky watchdog fault.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR. Reset enters IDLE.
- **IDLE:** if `run` is high, go to FETCH.
- **FETCH:** `mem_req=1`, `mem_addr_sel=0`. On `mem_ack`, assert `ir_load` in that same cycle and go to DECODE.
- **DECODE:** one cycle. At the end of the cycle, register these internal flags from the decoder inputs:
  - `is_mem = read_word | enable_write`.
  - `is_br = type_inst==11 && opcode in {04, 05}`.
  - `is_jr = type_inst==11 && opcode in {12, 13}` (JR, JALR).
  - `is_j = type_inst==10`.
  - `wb_need = (enable_reg | link) && !(is_br || opcode 12 in I || opcode 02 in J)`.
- **EXEC:** one cycle; `pc_load=1` always.
  - `pc_src=10` when `is_jr`.
  - `pc_src=01` when `is_j`, or when BEQZ with `rs1_zero=1`, or BNEZ with `rs1_zero=0`.
  - `pc_src=00` otherwise.
  - Next state: MEM if `is_mem`, else WB if `wb_need`, else the boundary.
- **MEM:** `mem_req=1`, `mem_addr_sel=1`, `mem_we=enable_write` (latched). On `mem_ack`: go to WB if the instruction is a load, else the boundary.
- **WB:** one cycle.
  - `reg_we=1`.
  - `wb_sel=01` for a load, `10` if `link`, else `00`.
  - `rd_r31=link`.
  - Then the boundary.
- **Boundary:** `retire=1` in the final cycle of the instruction. Next state is FETCH if `run` is high, else IDLE. Deasserting `run` mid-instruction never aborts the instruction.
- **ERR:** all outputs 0 except `err=1`. Only `reset` exits ERR.

## Timing
- Reset values: all outputs 0, state IDLE, watchdog counter 0.
- Outputs decode from the state and the latched flags. `ir_load`, `retire` and the MEM→WB transition also depend on `mem_ack` in the current cycle.
- Latency with zero-wait memory (`mem_ack` in the request cycle):
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch, J, JR: 3 cycles.
  - Each wait cycle on `mem_ack` adds one cycle.
- `mem_req` rises on entry to FETCH/MEM and falls in the cycle after `mem_ack` is sampled. `mem_ack` outside FETCH/MEM is ignored.
- Reset asserted mid-instruction clears the state to IDLE immediately. No retire occurs and there is no partial write.

## Configuration
- `DLX_SEQ_WATCHDOG_EN` defined:
  - An 8+ bit counter (sized from `TIMEOUT_CYCLES`) increments each cycle that `mem_req=1` and `mem_ack=0`.
  - The counter clears on `mem_ack` or on leaving FETCH/MEM.
  - When the counter reaches `TIMEOUT_CYCLES`, go to ERR on the next edge.
- Undefined: no counter; the sequencer waits indefinitely; `err` is tied to 0.

## Test plan
- **Reset and idle:** reset high, then low with `run=0` for 10 cycles → all outputs 0, `busy=0`.
- **ALU, zero-wait:** `run=1`, R-type ADD (type 01, opcode 20), `mem_ack` tied high → `retire` on cycle 4; `reg_we=1`, `wb_sel=00` in cycle 4; `pc_src=00`.
- **LW with waits:** `mem_ack` delayed 2 cycles in both FETCH and MEM → `retire` on cycle 9; `wb_sel=01` in WB. SW: `mem_we=1` in MEM, no `reg_we`.
- **Branches:** BEQZ with `rs1_zero=1` → EXEC `pc_src=01`, retire on cycle 3. BNEZ with `rs1_zero=1` → `pc_src=00`. JALR → `pc_src=10`, then WB with `wb_sel=10`, `rd_r31=1`.
- **Run drop:** `run` cleared in DECODE → instruction completes, then IDLE, `busy=0`.
- **Watchdog (macro defined, `TIMEOUT_CYCLES=4`):** `mem_ack` held low in FETCH → ERR after 4 wait cycles with `err=1` and `mem_req=0`. `err` stays high until reset. Without the macro the sequencer stays in FETCH.
